pixel_buffer: RTL
=================

// Module: pixel_buffer
// PURPOSE
//  Responder end of the single-pixel buffer bus driven by the GPU command processor
//  (x_b/y_b/read_b/write_b/in_b -> out_b/rdy_b). Holds a 320x200 1-bit framebuffer in
//  a 4000x16 synchronous single-port RAM. Serves pixel reads, and pixel writes as
//  read-modify-write. Gives the VGA scanout a word read port with priority.
// PARAMETERS
//  WIDTH        320   pixels per row; multiple of 16
//  HEIGHT       200   rows
//  WORDS_PER_ROW 20   WIDTH/16; the RAM is WORDS_PER_ROW*HEIGHT = 4000 words of 16 bits
// PORTS
//  clk        in   1   sole clock
//  rst        in   1   asynchronous reset, active-high
//  x_b        in   9   pixel column
//  y_b        in   8   pixel row
//  read_b     in   1   one-cycle read request pulse
//  write_b    in   1   one-cycle write request pulse
//  in_b       in   1   pixel value to write
//  out_b      out  1   pixel value read; valid while rdy_b=1 after a read
//  rdy_b      out  1   1 = idle/result valid, 0 = request in progress
//  scan_addr  in   12  scanout word address, y*20 + x/16
//  scan_req   in   1   scanout word read request, one cycle
//  scan_data  out  16  scanout word; bit i = pixel x = 16*(addr%20) + i
//  scan_valid out  1   one-cycle strobe; scan_data valid, 2 edges after scan_req
// BEHAVIOUR
//  - Reset: rdy_b=0, out_b=0, scan_data=0, scan_valid=0; FSM -> IDLE
//    (-> CLEAR with the macro). Reset mid-operation aborts it; a half-done RMW is lost.
//  - Addressing: word = (y<<4)+(y<<2)+x[8:4], 12-bit; bit = x[3:0].
//  - At the edge that samples read_b|write_b=1 in IDLE:
//    - latch x, y and in_b; drive rdy_b to 0 at that same edge.
//      The requester tests "!read_b && rdy_b" on the next edge, so rdy_b must already be low.
//    - Both read_b and write_b high: treat as a write.
//    - Requests sampled outside IDLE are ignored.
//  - FSM states: IDLE, RD_ISSUE, RD_DATA, WR_ISSUE, WR_DATA, WR_BACK, CLEAR (macro only).
//    - Read: IDLE -> RD_ISSUE (RAM addr) -> RD_DATA (word back; out_b <= word[bit],
//      rdy_b <= 1) -> IDLE. rdy_b rises 3 edges after the sampling edge.
//    - Write: IDLE -> WR_ISSUE -> WR_DATA (merge word[bit] = in_b) -> WR_BACK (RAM write,
//      rdy_b <= 1) -> IDLE. rdy_b rises 4 edges after the sampling edge.
//  - Out of range (x>=320 or y>=200): no RAM access; rdy_b rises 1 edge after sampling.
//    Read returns out_b=0; write is dropped.
//  - out_b holds its last read value until the next read completes.
//  - Arbitration: scan_req wins the RAM in any cycle. RD_ISSUE, WR_ISSUE and WR_BACK
//    stall one cycle per collision. Core latency grows by that many cycles; scanout
//    latency never changes.
//    - scan_req while an issued core read is in flight is legal: RAM output is tagged.
//    - scan_addr >= 4000 returns 0 and still strobes scan_valid.
//  - A scanout read of a word under RMW returns the pre-write value if the RAM access
//    precedes WR_BACK, otherwise the new value; no forwarding.
// CONFIGURATION
//  FB_CLEAR_ON_RESET_EN defined:
//    - After reset release, CLEAR writes 0 to words 0..3999, one per cycle.
//    - Scan collisions stall the sweep.
//    - rdy_b stays 0; bus requests are ignored.
//    - rdy_b rises the edge after word 3999 is written: 4000 edges without scan traffic.
//  FB_CLEAR_ON_RESET_EN undefined: no CLEAR state; RAM contents are undefined after power-up
//    and kept across reset; rdy_b rises at the first edge after rst falls.
// TESTING
//  1 Reset, no macro: rst 1->0 -> rdy_b=0 during rst, 1 one edge later; out_b=0,
//    scan_valid=0.
//  2 write (x=17,y=3,in=1), then read (17,3):
//    - write: rdy_b low 4 edges;
//    - read: rdy_b low 3 edges, out_b=1;
//    - read (16,3) -> out_b=0 (when cleared).
//  3 Scan word 61 (=3*20+1) after test 2 -> scan_data=16'h0002, scan_valid 2 edges
//    after scan_req.
//  4 scan_req every cycle for 5 cycles during a read -> read completes in 3+5 edges;
//    all 5 scan_valid strobes present.
//  5 write (320,0,1) and read (0,200) -> rdy_b back in 1 edge; out_b=0; RAM unchanged
//    (scan word 0 unchanged).
//  6 FB_CLEAR_ON_RESET_EN, RAM preloaded 16'hFFFF: reset -> rdy_b=0 for 4000 edges;
//    every scan word = 0; read_b pulse during CLEAR ignored.

Source files
------------

// File: rtl/pixel_buffer.sv
// Single-pixel responder over a 1-bit framebuffer in a 16-bit single-port RAM, with a
// priority word read port for scanout. Define FB_CLEAR_ON_RESET_EN to zero the RAM after reset.
module pixel_buffer #(
    parameter int unsigned WIDTH         = 320,
    parameter int unsigned HEIGHT        = 200,
    parameter int unsigned WORDS_PER_ROW = WIDTH / 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  x_b,
    input  logic [7:0]  y_b,
    input  logic        read_b,
    input  logic        write_b,
    input  logic        in_b,
    output logic        out_b,
    output logic        rdy_b,
    input  logic [11:0] scan_addr,
    input  logic        scan_req,
    output logic [15:0] scan_data,
    output logic        scan_valid
);
    localparam int unsigned DEPTH = WORDS_PER_ROW * HEIGHT;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdData,
        StWrIssue,
        StWrData,
        StWrBack
`ifdef FB_CLEAR_ON_RESET_EN
        , StClear
`endif
    } state_e;

    state_e      state_q;
    logic [11:0] addr_q;
    logic [3:0]  bit_q;
    logic        in_q;
    logic [15:0] wdata_q;
`ifdef FB_CLEAR_ON_RESET_EN
    logic [11:0] clr_q;
`endif

    logic [15:0] mem [DEPTH];
    logic [15:0] ram_rdata_q;
    logic        rd_scan_q, rd_oor_q, rd_core_q;
    logic        core_valid_q;
    logic [15:0] core_word_q;

    logic [11:0] req_addr;
    logic        req_in_range;
    logic        scan_in_range;
    logic        core_rd;
    logic [11:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we, ram_re;
    logic [15:0] merged;

    always_comb begin
        req_addr      = 12'(y_b) * 12'(WORDS_PER_ROW) + 12'(x_b[8:4]);
        req_in_range  = (x_b < 9'(WIDTH)) && (y_b < 8'(HEIGHT));
        scan_in_range = scan_addr < 12'(DEPTH);
        core_rd       = !scan_req && (state_q == StRdIssue || state_q == StWrIssue);
        merged        = core_word_q;
        merged[bit_q] = in_q;
    end

    // Scanout owns the RAM whenever it asks; the core simply retries next cycle.
    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        if (scan_req) begin
            ram_addr = scan_addr;
            ram_re   = scan_in_range;
        end else if (core_rd) begin
            ram_re = 1'b1;
        end else if (state_q == StWrBack) begin
            ram_we = 1'b1;
        end
`ifdef FB_CLEAR_ON_RESET_EN
        else if (state_q == StClear) begin
            ram_addr  = clr_q;
            ram_wdata = 16'h0000;
            ram_we    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end else if (ram_re) begin
            ram_rdata_q <= mem[ram_addr];
        end
    end

    // Tags follow each RAM read so scan and core results are routed independently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_scan_q    <= 1'b0;
            rd_oor_q     <= 1'b0;
            rd_core_q    <= 1'b0;
            scan_valid   <= 1'b0;
            scan_data    <= 16'h0000;
            core_valid_q <= 1'b0;
            core_word_q  <= 16'h0000;
        end else begin
            rd_scan_q    <= scan_req;
            rd_oor_q     <= scan_req && !scan_in_range;
            rd_core_q    <= core_rd;
            scan_valid   <= rd_scan_q;
            core_valid_q <= rd_core_q;
            if (rd_scan_q) begin
                scan_data <= rd_oor_q ? 16'h0000 : ram_rdata_q;
            end
            if (rd_core_q) begin
                core_word_q <= ram_rdata_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef FB_CLEAR_ON_RESET_EN
            state_q <= StClear;
            clr_q   <= 12'd0;
`else
            state_q <= StIdle;
`endif
            rdy_b   <= 1'b0;
            out_b   <= 1'b0;
            addr_q  <= 12'd0;
            bit_q   <= 4'd0;
            in_q    <= 1'b0;
            wdata_q <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (read_b || write_b) begin
                        rdy_b  <= 1'b0;
                        addr_q <= req_addr;
                        bit_q  <= x_b[3:0];
                        in_q   <= in_b;
                        if (!req_in_range) begin
                            // Stay idle; rdy_b comes back next edge with no RAM access.
                            if (!write_b) out_b <= 1'b0;
                        end else begin
                            state_q <= write_b ? StWrIssue : StRdIssue;
                        end
                    end else begin
                        rdy_b <= 1'b1;
                    end
                end
                StRdIssue: if (!scan_req) state_q <= StRdData;
                StRdData: begin
                    if (core_valid_q) begin
                        out_b   <= core_word_q[bit_q];
                        rdy_b   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StWrIssue: if (!scan_req) state_q <= StWrData;
                StWrData: begin
                    if (core_valid_q) begin
                        wdata_q <= merged;
                        state_q <= StWrBack;
                    end
                end
                StWrBack: begin
                    if (!scan_req) begin
                        rdy_b   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
`ifdef FB_CLEAR_ON_RESET_EN
                StClear: begin
                    if (!scan_req) begin
                        clr_q <= clr_q + 12'd1;
                        if (clr_q == 12'(DEPTH - 1)) begin
                            rdy_b   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
